// File: rtl/cpu6502_rmw_sequencer.sv
// Read-modify-write sequencer for 6502 INC/DEC/ASL/LSR/ROL/ROR/SMB/RMB: read, dummy, write via the shared ALU.
// Build option CPU6502_CMOS_RMW_EN: dummy cycle becomes a second read (65C02) instead of an NMOS write-back.
module cpu6502_rmw_sequencer #(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic [ADDR_WIDTH-1:0] cmdAddr,
    input  logic [3:0]            cmdOp,
    input  logic [2:0]            cmdOpExt,
    input  logic [7:0]            flagsIn,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memRead,
    output logic                  memWrite,
    output logic [7:0]            memWData,
    input  logic [7:0]            memRData,
    input  logic                  memReady,
    output logic [7:0]            aluOperandA,
    output logic [3:0]            aluOperation,
    output logic [2:0]            aluOpExtension,
    output logic                  aluCarryIn,
    output logic                  aluOverflowIn,
    output logic                  aluDecimalMode,
    input  logic [7:0]            aluResult,
    input  logic                  aluCarryOut,
    input  logic                  aluZero,
    input  logic                  aluNegative,
    output logic                  done,
    output logic                  error,
    output logic [7:0]            flagsOut,
    output logic [2:0]            dbgState
);

    // Handshakes: a command transfers on the rising edge where cmdValid & cmdReady are both high.
    // A bus access (memRead or memWrite) holds address/data stable and completes on the edge where
    // memReady is high; memRData is sampled on that same edge for reads.

    // ALU operation codes shared with the ALU decoder.
    localparam logic [3:0] ALU_OP_INC    = 4'd1;
    localparam logic [3:0] ALU_OP_DEC    = 4'd2;
    localparam logic [3:0] ALU_OP_SGL    = 4'd3;
    localparam logic [3:0] ALU_OP_SETBIT = 4'd4;
    localparam logic [3:0] ALU_OP_CLRBIT = 4'd5;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_DUMMY = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            op_q, op_d;
    logic [2:0]            ext_q, ext_d;
    logic [7:0]            flags_q, flags_d;
    logic [7:0]            data_q, data_d;
    logic [7:0]            result_q, result_d;
    logic [7:0]            new_flags_q, new_flags_d;
    logic [7:0]            flags_out_q, flags_out_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;

    logic in_access;
    logic timeout_hit;
    logic op_is_arith;
    logic op_is_bit;

    assign in_access   = (state_q == S_READ) || (state_q == S_DUMMY) || (state_q == S_WRITE);
    assign timeout_hit = in_access && !memReady && (wait_cnt_q == CNT_LAST);
    assign op_is_arith = (op_q == ALU_OP_INC) || (op_q == ALU_OP_DEC) || (op_q == ALU_OP_SGL);
    assign op_is_bit   = (op_q == ALU_OP_SETBIT) || (op_q == ALU_OP_CLRBIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= '0;
            ext_q       <= '0;
            flags_q     <= '0;
            data_q      <= '0;
            result_q    <= '0;
            new_flags_q <= '0;
            flags_out_q <= '0;
            err_q       <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            ext_q       <= ext_d;
            flags_q     <= flags_d;
            data_q      <= data_d;
            result_q    <= result_d;
            new_flags_q <= new_flags_d;
            flags_out_q <= flags_out_d;
            err_q       <= err_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        op_d        = op_q;
        ext_d       = ext_q;
        flags_d     = flags_q;
        data_d      = data_q;
        result_d    = result_q;
        new_flags_d = new_flags_q;
        flags_out_d = flags_out_q;
        err_d       = err_q;
        wait_cnt_d  = wait_cnt_q;

        // A stalled access either counts another wait cycle or aborts the whole command.
        if (in_access && !memReady) begin
            if (timeout_hit) begin
                state_d     = S_DONE;
                err_d       = 1'b1;
                flags_out_d = flags_q;
                wait_cnt_d  = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cmdValid) begin
                    addr_d     = cmdAddr;
                    op_d       = cmdOp;
                    ext_d      = cmdOpExt;
                    flags_d    = flagsIn;
                    err_d      = 1'b0;
                    wait_cnt_d = '0;
                    state_d    = S_READ;
                end
            end
            S_READ: begin
                if (memReady) begin
                    data_d     = memRData;
                    wait_cnt_d = '0;
                    state_d    = S_DUMMY;
                end
            end
            S_DUMMY: begin
                if (memReady) begin
                    // Unknown opcodes behave as COPY: value unchanged, Z/N re-derived from it.
                    if (op_is_arith) begin
                        result_d    = aluResult;
                        new_flags_d = {aluNegative, flags_q[6:2], aluZero, aluCarryOut};
                    end else if (op_is_bit) begin
                        result_d    = aluResult;
                        new_flags_d = flags_q;
                    end else begin
                        result_d    = data_q;
                        new_flags_d = {data_q[7], flags_q[6:2], (data_q == 8'd0), flags_q[0]};
                    end
                    wait_cnt_d = '0;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                if (memReady) begin
                    flags_out_d = new_flags_q;
                    wait_cnt_d  = '0;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        memRead  = 1'b0;
        memWrite = 1'b0;
        memAddr  = '0;
        memWData = '0;
        case (state_q)
            S_READ: begin
                memRead = 1'b1;
                memAddr = addr_q;
            end
            S_DUMMY: begin
                memAddr = addr_q;
`ifdef CPU6502_CMOS_RMW_EN
                memRead  = 1'b1;
`else
                memWrite = 1'b1;
                memWData = data_q;
`endif
            end
            S_WRITE: begin
                memWrite = 1'b1;
                memAddr  = addr_q;
                memWData = result_q;
            end
            default: begin
                memRead  = 1'b0;
                memWrite = 1'b0;
            end
        endcase
    end

    assign cmdReady       = (state_q == S_IDLE);
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_DONE) && err_q;
    assign flagsOut       = flags_out_q;
    assign dbgState       = state_q;

    assign aluOperandA    = data_q;
    assign aluOperation   = op_q;
    assign aluOpExtension = ext_q;
    assign aluCarryIn     = flags_q[0];
    assign aluOverflowIn  = flags_q[6];
    assign aluDecimalMode = 1'b0;

endmodule

// File: tb/tb_cpu6502_rmw_sequencer.sv
// Directed plus randomized bench for cpu6502_rmw_sequencer with a behavioural RMW reference model.
// Honours CPU6502_CMOS_RMW_EN the same way as the design.
module tb_cpu6502_rmw_sequencer;

    localparam int TMO = 4;
    localparam logic [3:0] OP_INC    = 4'd1;
    localparam logic [3:0] OP_DEC    = 4'd2;
    localparam logic [3:0] OP_SGL    = 4'd3;
    localparam logic [3:0] OP_SETBIT = 4'd4;
    localparam logic [3:0] OP_CLRBIT = 4'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmdValid;
    logic        cmdReady;
    logic [15:0] cmdAddr;
    logic [3:0]  cmdOp;
    logic [2:0]  cmdOpExt;
    logic [7:0]  flagsIn;
    logic [15:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [7:0]  memWData;
    logic [7:0]  memRData;
    logic        memReady;
    logic [7:0]  aluOperandA;
    logic [3:0]  aluOperation;
    logic [2:0]  aluOpExtension;
    logic        aluCarryIn;
    logic        aluOverflowIn;
    logic        aluDecimalMode;
    logic [7:0]  aluResult;
    logic        aluCarryOut;
    logic        aluZero;
    logic        aluNegative;
    logic        done;
    logic        error;
    logic [7:0]  flagsOut;
    logic [2:0]  dbgState;

    logic [7:0]  mem [0:65535];
    int          total_checks = 0;
    int          passed_checks = 0;

    always #5 clk = ~clk;

    cpu6502_rmw_sequencer #(
        .ADDR_WIDTH(16),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdAddr(cmdAddr),
        .cmdOp(cmdOp), .cmdOpExt(cmdOpExt), .flagsIn(flagsIn),
        .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
        .memWData(memWData), .memRData(memRData), .memReady(memReady),
        .aluOperandA(aluOperandA), .aluOperation(aluOperation),
        .aluOpExtension(aluOpExtension), .aluCarryIn(aluCarryIn),
        .aluOverflowIn(aluOverflowIn), .aluDecimalMode(aluDecimalMode),
        .aluResult(aluResult), .aluCarryOut(aluCarryOut), .aluZero(aluZero),
        .aluNegative(aluNegative),
        .done(done), .error(error), .flagsOut(flagsOut), .dbgState(dbgState)
    );

    // Stand-in ALU; unknown/bit ops produce junk carry/result so the sequencer must ignore them.
    always_comb begin
        aluResult   = ~aluOperandA;
        aluCarryOut = ~aluCarryIn;
        case (aluOperation)
            OP_INC: begin aluResult = aluOperandA + 8'd1; aluCarryOut = aluCarryIn; end
            OP_DEC: begin aluResult = aluOperandA - 8'd1; aluCarryOut = aluCarryIn; end
            OP_SGL: begin
                case (aluOpExtension[1:0])
                    2'd0:    {aluCarryOut, aluResult} = {aluOperandA, 1'b0};
                    2'd1:    {aluResult, aluCarryOut} = {1'b0, aluOperandA};
                    2'd2:    {aluCarryOut, aluResult} = {aluOperandA, aluCarryIn};
                    default: {aluResult, aluCarryOut} = {aluCarryIn, aluOperandA};
                endcase
            end
            OP_SETBIT: aluResult = aluOperandA | (8'd1 << aluOpExtension);
            OP_CLRBIT: aluResult = aluOperandA & ~(8'd1 << aluOpExtension);
            default:   aluResult = ~aluOperandA;
        endcase
        aluZero     = (aluResult == 8'd0);
        aluNegative = aluResult[7];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) begin
            passed_checks++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: final value and P register from the instruction's architectural meaning.
    function automatic void ref_rmw(input logic [3:0] op, input logic [2:0] ext, input logic [7:0] v,
                                    input logic [7:0] p, output logic [7:0] res, output logic [7:0] pout);
        int vi;
        int r;
        int c;
        vi   = int'(v);
        c    = int'(p[0]);
        r    = vi;
        pout = p;
        case (op)
            OP_INC: r = (vi + 1) % 256;
            OP_DEC: r = (vi + 255) % 256;
            OP_SGL: begin
                case (ext[1:0])
                    2'd0:    begin r = (vi * 2) % 256;     c = vi / 128; end
                    2'd1:    begin r = vi / 2;             c = vi % 2;   end
                    2'd2:    begin r = (vi * 2 + c) % 256; c = vi / 128; end
                    default: begin r = vi / 2 + c * 128;   c = vi % 2;   end
                endcase
            end
            OP_SETBIT: r = vi | (1 << ext);
            OP_CLRBIT: r = vi & ~(1 << ext) & 255;
            default:   r = vi;
        endcase
        res = r[7:0];
        if (op != OP_SETBIT && op != OP_CLRBIT) begin
            pout[0] = c[0];
            pout[1] = (r == 0);
            pout[7] = (r >= 128);
        end
    endfunction

    // One command with per-access wait states; stuck = index of an access that never completes, -1 none.
    task automatic run_cmd(input logic [15:0] a, input logic [3:0] op, input logic [2:0] ext,
                           input logic [7:0] fl, input logic [7:0] v,
                           input int w0, input int w1, input int w2, input int stuck);
        int         waits[3];
        bit         exp_is_rd[3];
        logic [7:0] exp_wd[3];
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [7:0] res;
        logic [7:0] ef;
        int         ncomp;
        int         exp_reads;
        int         reads;
        int         exp_done;
        int         acc;
        int         wleft;
        int         cyc;
        bit         seen_done;
        bit         rdy;

        waits = '{w0, w1, w2};
        mem[a] = v;
        ref_rmw(op, ext, v, fl, res, ef);
`ifdef CPU6502_CMOS_RMW_EN
        exp_is_rd = '{1'b1, 1'b1, 1'b0};
        exp_wd    = '{8'h00, 8'h00, res};
`else
        exp_is_rd = '{1'b1, 1'b0, 1'b0};
        exp_wd    = '{8'h00, v, res};
`endif
        ncomp = (stuck < 0) ? 3 : stuck;
        exp_reads = 0;
        for (int j = 0; j < ncomp; j++) begin
            if (exp_is_rd[j]) exp_reads++;
            else exp_q.push_back(exp_wd[j]);
        end
        if (stuck < 0) begin
            exp_done = 4 + w0 + w1 + w2;
        end else begin
            exp_done = 1 + TMO;
            for (int j = 0; j < stuck; j++) exp_done += waits[j] + 1;
            ef = fl;
        end

        memReady = 1'b0;
        cmdValid = 1'b1;
        cmdAddr  = a;
        cmdOp    = op;
        cmdOpExt = ext;
        flagsIn  = fl;
        for (int k = 0; k < 5 && !cmdReady; k++) @(negedge clk);
        check("cmd_ready", 32'(cmdReady), 32'd1);
        @(posedge clk);

        acc = 0;
        wleft = waits[0];
        cyc = 0;
        reads = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 60 && !seen_done; k++) begin
            @(negedge clk);
            cyc++;
            cmdValid = 1'($urandom_range(0, 1));
            cmdAddr  = 16'($urandom);
            cmdOp    = 4'($urandom);
            cmdOpExt = 3'($urandom);
            flagsIn  = 8'($urandom);
            memRData = 8'($urandom);
            if (done) begin
                seen_done = 1'b1;
                cmdValid  = 1'b0;
                memReady  = 1'b0;
                check("done_cycle", 32'(cyc), 32'(exp_done));
                check("error", 32'(error), 32'(stuck >= 0));
                check("flags_out", 32'(flagsOut), 32'(ef));
                check("done_bus_idle", 32'({memRead, memWrite}), 32'd0);
            end else if (acc < 3) begin
                check("bus_rd", 32'(memRead), 32'(exp_is_rd[acc]));
                check("bus_wr", 32'(memWrite), 32'(!exp_is_rd[acc]));
                check("bus_addr", 32'(memAddr), 32'(a));
                if (memWrite) check("bus_wdata", 32'(memWData), 32'(exp_wd[acc]));
                rdy = (acc != stuck) && (wleft == 0);
                memReady = rdy;
                if (rdy && memRead) memRData = mem[memAddr];
                if (rdy && acc == 1) begin
                    check("alu_a", 32'(aluOperandA), 32'(v));
                    check("alu_op", 32'({aluOperation, aluOpExtension}), 32'({op, ext}));
                    check("alu_cv", 32'({aluCarryIn, aluOverflowIn, aluDecimalMode}),
                          32'({fl[0], fl[6], 1'b0}));
                end
                if (rdy) begin
                    if (memRead) reads++;
                    if (memWrite) begin
                        got_q.push_back(memWData);
                        mem[memAddr] = memWData;
                    end
                    acc++;
                    wleft = (acc < 3) ? waits[acc] : 0;
                end else if (wleft > 0) begin
                    wleft--;
                end
            end else begin
                memReady = 1'b0;
                check("bus_idle_after_write", 32'({memRead, memWrite}), 32'd0);
            end
        end
        memReady = 1'b0;
        cmdValid = 1'b0;
        if (!seen_done) check("done_within_bound", 32'd0, 32'd1);
        check("read_count", 32'(reads), 32'(exp_reads));
        check("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            check("write_data", 32'(got_q[j]), 32'(exp_q[j]));
    endtask

    // Reset lands while the final write waits; the write and done pulse must both vanish.
    task automatic reset_mid_write(input logic [7:0] v);
        bit saw_done;
        cmdValid = 1'b1;
        cmdAddr  = 16'h1234;
        cmdOp    = OP_INC;
        cmdOpExt = 3'd0;
        flagsIn  = 8'h00;
        memReady = 1'b0;
        for (int k = 0; k < 5 && !cmdReady; k++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0;
        memReady = 1'b1;
        memRData = v;
        @(negedge clk);
        memReady = 1'b1;
        @(negedge clk);
        memReady = 1'b0;
        check("rst_pre_write", 32'(memWrite), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_no_write", 32'(memWrite), 32'd0);
        check("rst_no_read", 32'(memRead), 32'd0);
        check("rst_cmd_ready", 32'(cmdReady), 32'd1);
        reset = 1'b0;
        saw_done = done;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("rst_no_done", 32'(saw_done), 32'd0);
    endtask

    initial begin
        logic [3:0] rop;
        int         st;
        reset    = 1'b1;
        cmdValid = 1'b0;
        cmdAddr  = '0;
        cmdOp    = '0;
        cmdOpExt = '0;
        flagsIn  = '0;
        memRData = '0;
        memReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cmd_ready", 32'(cmdReady), 32'd1);
        check("reset_bus", 32'({memRead, memWrite}), 32'd0);
        check("reset_done_error", 32'({done, error}), 32'd0);
        check("reset_mem_addr", 32'(memAddr), 32'd0);
        check("reset_mem_wdata", 32'(memWData), 32'd0);
        check("reset_flags_out", 32'(flagsOut), 32'd0);
        check("reset_dbg_state", 32'(dbgState), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_cmd(16'h0042, OP_INC, 3'd0, 8'h01, 8'h7F, 0, 0, 0, -1);
        check("inc_flags_literal", 32'(flagsOut), 32'h81);
        run_cmd(16'h0300, OP_SGL, 3'd0, 8'h00, 8'h80, 0, 0, 0, -1);
        check("asl_flags_literal", 32'(flagsOut), 32'h03);
        run_cmd(16'h00F0, OP_DEC, 3'd0, 8'h00, 8'h01, 3, 0, 0, -1);
        check("dec_z_literal", 32'(flagsOut[1]), 32'd1);
        run_cmd(16'h0010, OP_INC, 3'd0, 8'hC5, 8'h10, 0, 0, 0, 2);
        run_cmd(16'h0011, OP_SETBIT, 3'd3, 8'h24, 8'h00, 0, 0, 0, -1);
        run_cmd(16'h0012, OP_CLRBIT, 3'd7, 8'hE7, 8'hFF, 1, 2, 1, -1);
        run_cmd(16'h0013, 4'd0, 3'd2, 8'h40, 8'h00, 0, 1, 0, -1);
        run_cmd(16'h0014, 4'd15, 3'd5, 8'h03, 8'hA5, 0, 0, 2, -1);
        run_cmd(16'h0015, OP_SGL, 3'd3, 8'h01, 8'h01, 0, 0, 0, -1);
        run_cmd(16'h8000, OP_SGL, 3'd2, 8'h00, 8'hFF, 0, 0, 0, 0);
        run_cmd(16'hFFFF, OP_DEC, 3'd0, 8'h80, 8'h00, 2, 0, 0, 1);

        reset_mid_write(8'h55);
        run_cmd(16'h1234, OP_INC, 3'd0, 8'h00, 8'hFF, 0, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0:       rop = OP_INC;
                1:       rop = OP_DEC;
                2:       rop = OP_SGL;
                3:       rop = OP_SETBIT;
                4:       rop = OP_CLRBIT;
                5:       rop = 4'd0;
                default: rop = 4'($urandom_range(6, 15));
            endcase
            st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1;
            run_cmd(16'($urandom), rop, 3'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, TMO - 1)), int'($urandom_range(0, TMO - 1)),
                    int'($urandom_range(0, TMO - 1)), st);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
